// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC controller: BTB-predicted next PC, EX redirect with one-cycle
// recovery, BTB-hit flag pipeline to ID/EX and saturating statistics counters.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic [31:0]      i_predicted_pc_IF,
   input  logic             i_btb_hit,
   input  logic             i_mispredict,
   input  logic [31:0]      i_redirect_pc,
   output logic [31:0]      o_pc_IF,
   output logic [31:0]      o_pc_plus4_IF,
   output logic             o_btb_hit_ID,
   output logic             o_btb_hit_EX,
   output logic             o_flush,
   output logic             o_recover,
   output logic [CNT_W-1:0] o_mispredict_cnt,
   output logic [CNT_W-1:0] o_hit_cnt
);

   typedef enum logic {RUN, RECOVER} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             hit_id_q, hit_id_d;
   logic             hit_ex_q, hit_ex_d;
   logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             acc_mp;

   // The EX slot after a redirect is a squashed bubble, so its mispredict is ignored.
   // Gating with reset keeps o_flush low while reset is held.
   assign acc_mp = i_mispredict && (state_q == RUN) && !i_rst;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      hit_id_d  = hit_id_q;
      hit_ex_d  = hit_ex_q;
      mp_cnt_d  = mp_cnt_q;
      hit_cnt_d = hit_cnt_q;
      unique case (state_q)
         RUN:     state_d = acc_mp ? RECOVER : RUN;
         RECOVER: state_d = RUN;
         default: state_d = RUN;
      endcase
      if (acc_mp) begin
         pc_d     = {i_redirect_pc[31:2], 2'b00};
         hit_id_d = 1'b0;
         hit_ex_d = 1'b0;
         if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_W'(1);
      end else if (!i_stall) begin
         pc_d     = {i_predicted_pc_IF[31:2], 2'b00};
         hit_id_d = i_btb_hit;
         hit_ex_d = hit_id_q;
         if (i_btb_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         hit_id_q  <= 1'b0;
         hit_ex_q  <= 1'b0;
         mp_cnt_q  <= '0;
         hit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         hit_id_q  <= hit_id_d;
         hit_ex_q  <= hit_ex_d;
         mp_cnt_q  <= mp_cnt_d;
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign o_pc_IF          = pc_q;
   assign o_pc_plus4_IF    = pc_q + 32'd4;
   assign o_btb_hit_ID     = hit_id_q;
   assign o_btb_hit_EX     = hit_ex_q;
   assign o_flush          = acc_mp;
   assign o_recover        = (state_q == RECOVER);
   assign o_mispredict_cnt = mp_cnt_q;
   assign o_hit_cnt        = hit_cnt_q;

endmodule
